// File: rtl/sd_dat_rx_ctrl.sv
// sd_dat_rx_ctrl: Avalon-MM single-block 4-bit SD DAT read engine.
// Generates sd_clk, finds the start bit, packs nibbles into 32-bit
// words, checks the per-line CRC16 and buffers words in a FIFO.
// Ports: clk, reset (sync, active-high); Avalon slave address,
// chipselect, write_n, read_n, writedata, readdata (1-cycle latency);
// sd_clk, sd_dat_in[3:0]; irq.
// Regs: 0 CTRL/STATUS, 1 BLOCK_LEN, 2 DATA (pop), 3 IRQ_CTRL.
// Option: define SD_DAT_RX_IRQ_EN to enable IRQ_CTRL and irq.
module sd_dat_rx_ctrl #(
  parameter int CLK_DIV     = 4,
  parameter int BLOCK_BYTES = 512,
  parameter int TIMEOUT_CYC = 65535,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sd_clk,
  input  logic [3:0]  sd_dat_in,
  output logic        irq
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DATA, S_CRC, S_END
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0] div_cnt;
  logic [TO_W-1:0]  wait_cnt;
  logic [12:0]      nib_cnt;
  logic [3:0]       crc_cnt;
  logic [31:0]      word_buf;
  logic             word_vld;
  logic [15:0]      crc [4];
  logic [11:0]      block_len;
  logic             done, crc_err, timeout;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [CW-1:0]    wr_ptr, rd_ptr, fifo_cnt;
  logic             fifo_empty, fifo_full;
  logic             push, pop;

  logic             busy, stall, rise, last_nib;
  logic             ctrl_wr, len_wr;
  logic             start_cmd, abort_cmd;
  logic [31:0]      rd_mux;
  logic             irq_en;
  logic             unused_ok;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic        b
  );
    return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
  endfunction

  assign unused_ok = ^writedata[31:12];

  assign busy    = (state != S_IDLE);
  assign ctrl_wr = chipselect & ~write_n & (address == 2'd0);
  assign len_wr  = chipselect & ~write_n & (address == 2'd1);

  // abort wins over start in the same write; start only from idle
  assign start_cmd = ctrl_wr & writedata[0] & ~writedata[1] & ~busy;
  assign abort_cmd = ctrl_wr & writedata[1] & busy;

  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign pop  = chipselect & ~read_n & (address == 2'd2) & ~fifo_empty;
  assign push = word_vld & ~fifo_full;

  // hold sd_clk low while a finished word has nowhere to go
  assign stall = word_vld & fifo_full & ~sd_clk;
  assign rise  = busy & ~stall & ~sd_clk &
                 (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_nib = (nib_cnt == ({block_len, 1'b0} - 13'd1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start_cmd) state_nxt = S_WAIT;
      S_WAIT: begin
        if (rise) begin
          if (sd_dat_in == 4'h0)
            state_nxt = S_DATA;
          else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1))
            state_nxt = S_IDLE;
        end
      end
      S_DATA: if (rise && last_nib) state_nxt = S_CRC;
      S_CRC:  if (rise && crc_cnt == 4'd15) state_nxt = S_END;
      S_END:  if (rise) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_cmd) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      sd_clk    <= 1'b0;
      wait_cnt  <= '0;
      nib_cnt   <= '0;
      crc_cnt   <= '0;
      word_buf  <= '0;
      word_vld  <= 1'b0;
      done      <= 1'b0;
      crc_err   <= 1'b0;
      timeout   <= 1'b0;
      block_len <= 12'(BLOCK_BYTES);
      for (int i = 0; i < 4; i++) crc[i] <= '0;
    end else begin
      if (!busy || abort_cmd) begin
        div_cnt <= '0;
        sd_clk  <= 1'b0;
      end else if (!stall) begin
        if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
          div_cnt <= '0;
          sd_clk  <= ~sd_clk;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end

      if (len_wr && !busy)
        block_len <= (writedata[11:2] == '0) ? 12'd4 :
                     {writedata[11:2], 2'b00};

      if (push || abort_cmd) word_vld <= 1'b0;

`ifdef SD_DAT_RX_IRQ_EN
      if (chipselect && !write_n && address == 2'd3 && writedata[1]) begin
        done    <= 1'b0;
        timeout <= 1'b0;
      end
`endif

      if (start_cmd) begin
        wait_cnt <= '0;
        nib_cnt  <= '0;
        crc_cnt  <= '0;
        word_vld <= 1'b0;
        done     <= 1'b0;
        crc_err  <= 1'b0;
        timeout  <= 1'b0;
        for (int i = 0; i < 4; i++) crc[i] <= '0;
      end

      if (rise && !abort_cmd) begin
        unique case (state)
          S_WAIT: begin
            if (sd_dat_in != 4'h0) begin
              wait_cnt <= wait_cnt + TO_W'(1);
              if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) timeout <= 1'b1;
            end
          end
          S_DATA: begin
            // high nibble first, byte k lands in word[8k+7:8k]
            word_buf[{nib_cnt[2:1], ~nib_cnt[0], 2'b00} +: 4] <= sd_dat_in;
            if (nib_cnt[2:0] == 3'd7) word_vld <= 1'b1;
            nib_cnt <= nib_cnt + 13'd1;
            for (int i = 0; i < 4; i++)
              crc[i] <= crc_step(crc[i], sd_dat_in[i]);
          end
          S_CRC: begin
            for (int i = 0; i < 4; i++) begin
              if (sd_dat_in[i] != crc[i][15]) crc_err <= 1'b1;
              crc[i] <= {crc[i][14:0], 1'b0};
            end
            crc_cnt <= crc_cnt + 4'd1;
          end
          S_END: begin
            if (sd_dat_in != 4'hF) crc_err <= 1'b1;
            done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start_cmd) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= word_buf;
  end

`ifdef SD_DAT_RX_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (chipselect && !write_n && address == 2'd3)
        irq_en <= writedata[0];
      irq <= irq_en & (done | timeout);
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    unique case (address)
      2'd0: rd_mux = {16'h0, 8'(fifo_cnt), 2'b00, fifo_full,
                      fifo_empty, timeout, crc_err, done, busy};
      2'd1: rd_mux = {20'h0, block_len};
      2'd2: rd_mux = fifo_empty ? 32'h0 : mem[rd_ptr[AW-1:0]];
      2'd3: rd_mux = {31'h0, irq_en};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

endmodule

// File: tb/tb_sd_dat_rx_ctrl.sv
// tb_sd_dat_rx_ctrl: randomized bench with an SD card model and
// reference CRC/packing model for sd_dat_rx_ctrl.
`timescale 1ns/1ps
module tb_sd_dat_rx_ctrl;

  localparam int CLK_DIV     = 2;
  localparam int BLOCK_BYTES = 512;
  localparam int TIMEOUT_CYC = 100;
  localparam int FIFO_DEPTH  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        sd_clk;
  logic [3:0]  sd_dat_in;
  logic        irq;

  int tests = 0;
  int fails = 0;

  logic [3:0]  txa [0:2047];
  logic [7:0]  bytes [0:255];
  logic [31:0] exp_w [$];
  int tx_len = 0;
  int base = 0;
  int rise_cnt = 0;
  int idx;

  sd_dat_rx_ctrl #(
    .CLK_DIV(CLK_DIV), .BLOCK_BYTES(BLOCK_BYTES),
    .TIMEOUT_CYC(TIMEOUT_CYC), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n), .read_n(read_n),
    .writedata(writedata), .readdata(readdata), .sd_clk(sd_clk),
    .sd_dat_in(sd_dat_in), .irq(irq)
  );

  always #5 clk = ~clk;

  // card: presents nibble n of the frame until the (n+1)th sd_clk rise
  always @(posedge sd_clk) rise_cnt++;
  assign idx = rise_cnt - base;
  assign sd_dat_in = (idx >= 0 && idx < tx_len) ? txa[idx[10:0]] : 4'hF;

  initial begin
    #800000;
    $display("FAIL watchdog: sim time exceeded, got timeout want finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic wait_idle(input int max_reads, output bit ok);
    logic [31:0] s;
    int k;
    ok = 1'b0;
    k = 0;
    while (!ok && k < max_reads) begin
      rd(2'd0, s);
      if (!s[0]) ok = 1'b1;
      k++;
    end
  endtask

  function automatic logic [31:0] exp_stat(
    input int cnt, input bit to, input bit ce, input bit dn, input bit by
  );
    return {16'h0, 8'(cnt), 2'b00, (cnt == FIFO_DEPTH), (cnt == 0),
            to, ce, dn, by};
  endfunction

  // CRC16 as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
  function automatic logic [15:0] line_crc(input int line, input int nb);
    logic [16:0] r;
    logic b;
    logic [7:0] by;
    r = '0;
    for (int k = 0; k < 2 * nb + 16; k++) begin
      if (k < 2 * nb) begin
        by = bytes[k / 2];
        b = (k % 2 == 0) ? by[4 + line] : by[line];
      end else begin
        b = 1'b0;
      end
      r = {r[15:0], b};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  task automatic build_frame(
    input int nb, input int pre, input int fl_line, input int fl_bit,
    input bit bad_end
  );
    logic [15:0] c [4];
    logic [3:0] nib;
    int n;
    n = 0;
    for (int p = 0; p < pre; p++) begin txa[n] = 4'hF; n++; end
    txa[n] = 4'h0; n++;
    for (int k = 0; k < 2 * nb; k++) begin
      txa[n] = (k % 2 == 0) ? bytes[k / 2][7:4] : bytes[k / 2][3:0];
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      c[i] = line_crc(i, nb);
      if (i == fl_line) c[i][fl_bit] = ~c[i][fl_bit];
    end
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) nib[i] = c[i][15 - k];
      txa[n] = nib; n++;
    end
    txa[n] = bad_end ? 4'h7 : 4'hF; n++;
    exp_w.delete();
    for (int w = 0; w < nb / 4; w++)
      exp_w.push_back({bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]});
    base = rise_cnt;
    tx_len = n;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    rd(2'd0, d);
    tests++;
    if (d !== 32'h0000_0010) begin
      fails++; $display("FAIL reset_status: got %h want %h", d, 32'h10);
    end
    tests++;
    if (sd_clk !== 1'b0) begin
      fails++; $display("FAIL reset_sd_clk: got %b want 0", sd_clk);
    end
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL reset_irq: got %b want 0", irq);
    end
    rd(2'd1, d);
    tests++;
    if (d !== 32'd512) begin
      fails++; $display("FAIL reset_block_len: got %0d want 512", d);
    end
    rd(2'd2, d);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL empty_pop: got %h want 0", d);
    end
    rd(2'd0, d);
    tests++;
    if (d !== 32'h0000_0010) begin
      fails++; $display("FAIL empty_pop_status: got %h want 10", d);
    end
    rd(2'd3, d);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL reset_irq_ctrl: got %h want 0", d);
    end
  endtask

  task automatic test_block_len;
    logic [31:0] d;
    wr(2'd1, 32'h0);
    rd(2'd1, d);
    tests++;
    if (d !== 32'd4) begin
      fails++; $display("FAIL len_zero: got %0d want 4", d);
    end
    wr(2'd1, 32'hFFFF_F7FF);
    rd(2'd1, d);
    tests++;
    if (d !== 32'h7FC) begin
      fails++; $display("FAIL len_mask: got %h want 7fc", d);
    end
    wr(2'd1, 32'h13);
    rd(2'd1, d);
    tests++;
    if (d !== 32'h10) begin
      fails++; $display("FAIL len_low_bits: got %h want 10", d);
    end
    wr(2'd0, 32'h3);
    idle(2);
    rd(2'd0, d);
    tests++;
    if (d[0] !== 1'b0) begin
      fails++; $display("FAIL abort_beats_start: got busy %b want 0", d[0]);
    end
  endtask

  task automatic test_basic(input int fl_line);
    logic [31:0] d;
    bit ok;
    bit ce;
    ce = (fl_line >= 0);
    for (int k = 0; k < 8; k++) bytes[k] = 8'(k + 1);
    build_frame(8, 2, fl_line, 3, 1'b0);
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h1);
    wait_idle(2000, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL basic_done_wait: got busy want idle");
    end
    idle(10);
    rd(2'd0, d);
    tests++;
    if (d !== exp_stat(2, 0, ce, 1, 0)) begin
      fails++;
      $display("FAIL basic_status: got %h want %h", d, exp_stat(2, 0, ce, 1, 0));
    end
    tests++;
    if (rise_cnt - base !== tx_len) begin
      fails++;
      $display("FAIL basic_rises: got %0d want %0d", rise_cnt - base, tx_len);
    end
    rd(2'd2, d);
    tests++;
    if (d !== 32'h04030201) begin
      fails++; $display("FAIL basic_word0: got %h want 04030201", d);
    end
    rd(2'd2, d);
    tests++;
    if (d !== 32'h08070605) begin
      fails++; $display("FAIL basic_word1: got %h want 08070605", d);
    end
    rd(2'd0, d);
    tests++;
    if (d !== exp_stat(0, 0, ce, 1, 0)) begin
      fails++;
      $display("FAIL basic_drained: got %h want %h", d, exp_stat(0, 0, ce, 1, 0));
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    bit ok;
    int nb, pre, fl;
    bit be, ce;
    for (int it = 0; it < 6; it++) begin
      nb  = 4 * $urandom_range(1, 8);
      pre = $urandom_range(0, 20);
      fl  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1;
      be  = ($urandom_range(0, 3) == 0);
      ce  = (fl >= 0) || be;
      for (int k = 0; k < nb; k++) bytes[k] = 8'($urandom);
      build_frame(nb, pre, fl, $urandom_range(0, 15), be);
      wr(2'd1, nb);
      wr(2'd0, 32'h1);
      wait_idle(3000, ok);
      tests++;
      if (!ok) begin
        fails++; $display("FAIL b2b_wait it%0d: got busy want idle", it);
      end
      rd(2'd0, d);
      tests++;
      if (d !== exp_stat(nb / 4, 0, ce, 1, 0)) begin
        fails++;
        $display("FAIL b2b_status it%0d: got %h want %h", it, d,
                 exp_stat(nb / 4, 0, ce, 1, 0));
      end
      for (int w = 0; w < nb / 4; w++) begin
        rd(2'd2, d);
        tests++;
        if (d !== exp_w[w]) begin
          fails++;
          $display("FAIL b2b_word it%0d w%0d: got %h want %h", it, w, d, exp_w[w]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d;
    bit ok;
    int k, r0;
    for (int i = 0; i < 64; i++) bytes[i] = 8'($urandom);
    build_frame(64, 1, -1, 0, 1'b0);
    wr(2'd1, 32'd64);
    wr(2'd0, 32'h1);
    ok = 1'b0;
    k = 0;
    while (!ok && k < 3000) begin
      rd(2'd0, d);
      if (d[5]) ok = 1'b1;
      k++;
    end
    tests++;
    if (!ok) begin
      fails++; $display("FAIL bp_full_wait: got not full want full");
    end
    idle(100);
    tests++;
    if (sd_clk !== 1'b0) begin
      fails++; $display("FAIL bp_clk_low: got %b want 0", sd_clk);
    end
    r0 = rise_cnt;
    idle(60);
    tests++;
    if (rise_cnt - base !== 1 + 1 + 72 || rise_cnt !== r0) begin
      fails++;
      $display("FAIL bp_stop_point: got %0d rises want %0d", rise_cnt - base, 74);
    end
    wr(2'd0, 32'h1);
    wr(2'd1, 32'h4);
    rd(2'd0, d);
    tests++;
    if (d !== exp_stat(8, 0, 0, 0, 1)) begin
      fails++;
      $display("FAIL bp_status: got %h want %h", d, exp_stat(8, 0, 0, 0, 1));
    end
    rd(2'd1, d);
    tests++;
    if (d !== 32'd64) begin
      fails++; $display("FAIL bp_len_busy: got %0d want 64", d);
    end
    for (int w = 0; w < 16; w++) begin
      idle(49);
      rd(2'd2, d);
      tests++;
      if (d !== exp_w[w]) begin
        fails++; $display("FAIL bp_word w%0d: got %h want %h", w, d, exp_w[w]);
      end
    end
    wait_idle(2000, ok);
    rd(2'd0, d);
    tests++;
    if (!ok || d !== exp_stat(0, 0, 0, 1, 0)) begin
      fails++;
      $display("FAIL bp_done: got %h want %h", d, exp_stat(0, 0, 0, 1, 0));
    end
  endtask

  task automatic test_timeout;
    logic [31:0] d;
    bit ok;
    tx_len = 0;
    base = rise_cnt;
`ifdef SD_DAT_RX_IRQ_EN
    wr(2'd3, 32'h1);
`endif
    wr(2'd0, 32'h1);
    wait_idle(2000, ok);
    idle(5);
    rd(2'd0, d);
    tests++;
    if (!ok || d !== exp_stat(0, 1, 0, 0, 0)) begin
      fails++;
      $display("FAIL to_status: got %h want %h", d, exp_stat(0, 1, 0, 0, 0));
    end
    tests++;
    if (rise_cnt - base !== TIMEOUT_CYC) begin
      fails++;
      $display("FAIL to_rises: got %0d want %0d", rise_cnt - base, TIMEOUT_CYC);
    end
    tests++;
    if (sd_clk !== 1'b0) begin
      fails++; $display("FAIL to_clk_low: got %b want 0", sd_clk);
    end
`ifdef SD_DAT_RX_IRQ_EN
    tests++;
    if (irq !== 1'b1) begin
      fails++; $display("FAIL to_irq: got %b want 1", irq);
    end
    wr(2'd3, 32'h3);
    idle(2);
    rd(2'd0, d);
    tests++;
    if (d[3] !== 1'b0 || irq !== 1'b0) begin
      fails++; $display("FAIL irq_clear: got to=%b irq=%b want 0 0", d[3], irq);
    end
    rd(2'd3, d);
    tests++;
    if (d !== 32'h1) begin
      fails++; $display("FAIL irq_en_read: got %h want 1", d);
    end
`else
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL to_irq: got %b want 0", irq);
    end
    wr(2'd3, 32'h3);
    rd(2'd0, d);
    tests++;
    if (d[3] !== 1'b1) begin
      fails++; $display("FAIL to_sticky: got %b want 1", d[3]);
    end
    rd(2'd3, d);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL irq_ctrl_read: got %h want 0", d);
    end
`endif
  endtask

  task automatic test_abort;
    logic [31:0] d;
    bit ok;
    int k, r0;
    for (int i = 0; i < 64; i++) bytes[i] = 8'($urandom);
    build_frame(64, 3, -1, 0, 1'b0);
    wr(2'd1, 32'd64);
    wr(2'd0, 32'h1);
    ok = 1'b0;
    k = 0;
    while (!ok && k < 2000) begin
      rd(2'd0, d);
      if (d[15:8] >= 8'd3) ok = 1'b1;
      k++;
    end
    wr(2'd0, 32'h2);
    rd(2'd0, d);
    tests++;
    if (!ok || d !== exp_stat(3, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL abort_status: got %h want %h", d, exp_stat(3, 0, 0, 0, 0));
    end
    r0 = rise_cnt;
    idle(50);
    tests++;
    if (sd_clk !== 1'b0 || rise_cnt !== r0) begin
      fails++;
      $display("FAIL abort_clk: got clk=%b rises=%0d want 0 %0d", sd_clk,
               rise_cnt - r0, 0);
    end
    for (int w = 0; w < 3; w++) begin
      rd(2'd2, d);
      tests++;
      if (d !== exp_w[w]) begin
        fails++; $display("FAIL abort_word w%0d: got %h want %h", w, d, exp_w[w]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    for (int i = 0; i < 64; i++) bytes[i] = 8'($urandom);
    build_frame(64, 2, -1, 0, 1'b0);
    wr(2'd1, 32'd64);
    wr(2'd0, 32'h1);
    idle(150);
    rd(2'd0, d);
    tests++;
    if (d[0] !== 1'b1 || d[15:8] == 8'd0) begin
      fails++; $display("FAIL mid_busy: got %h want busy with words", d);
    end
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    rd(2'd0, d);
    tests++;
    if (d !== 32'h10) begin
      fails++; $display("FAIL mid_reset_status: got %h want 10", d);
    end
    rd(2'd1, d);
    tests++;
    if (d !== 32'd512 || sd_clk !== 1'b0 || irq !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_regs: got len=%0d clk=%b irq=%b want 512 0 0",
               d, sd_clk, irq);
    end
    rd(2'd2, d);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL mid_reset_fifo: got %h want 0", d);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_block_len;
    test_basic(-1);
    test_basic(2);
    test_back_to_back;
    test_backpressure;
    test_timeout;
    test_abort;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
